muldiv_sequencer: RTL

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer_pkg.sv | 37 +++
 rtl/muldiv_datapath.sv | 114 +++++++++++
 rtl/muldiv_sequencer.sv | 119 +++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared processor defines for the M-extension multiply/divide unit.
// Holds the funct3 operation encoding, the sequencer state encoding and
// the default iteration count of the shift-add/shift-subtract loop.
package muldiv_sequencer_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned MD_ITERS_DEF = 32;

  // RISC-V funct3 encoding of the M-extension ops
  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  // funct3[2] separates divide/remainder from multiply
  function automatic logic md_is_div(input md_op_t op);
    return op[2];
  endfunction

  // funct3[1] selects remainder within the divide group
  function automatic logic md_is_rem(input md_op_t op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Multiply/divide datapath: operand magnitude/sign capture, 64-bit
// accumulator, one shift-add (multiply) or restoring shift-subtract (divide)
// step per cycle, and final sign fix-up / result select.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   load                capture operands/op and clear the accumulator
//   step                perform one iteration
//   op, src_a, src_b    operation and raw operands (sampled on load)
//   special_c           divide-by-zero or signed-overflow on the raw inputs
//   special_result_c    result for the special cases
//   result_c            fixed-up result after the step performed this cycle
module muldiv_datapath
  import muldiv_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  md_op_t          op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            special_c,
  output logic [XLEN-1:0] special_result_c,
  output logic [XLEN-1:0] result_c
);

  localparam int unsigned ACC_W = 2 * XLEN;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  md_op_t           op_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] mcand_q;   // multiplicand (shifts left) / dividend (MSB feeds divide)
  logic [XLEN-1:0]  mplier_q;  // multiplier (shifts right) / divisor magnitude (held)
  logic             neg_q;     // product / quotient needs negation
  logic             rem_neg_q; // remainder takes the dividend sign

  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_by_zero, div_ovf;

  // Operand sign handling and special-case detection on the raw inputs
  always_comb begin
    a_signed    = (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    b_signed    = (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    a_neg       = a_signed & src_a[XLEN-1];
    b_neg       = b_signed & src_b[XLEN-1];
    a_mag       = a_neg ? -src_a : src_a;
    b_mag       = b_neg ? -src_b : src_b;
    div_by_zero = md_is_div(op) && (src_b == '0);
    div_ovf     = ((op == MD_DIV) || (op == MD_REM)) && (src_a == INT_MIN) && (src_b == '1);
    special_c   = div_by_zero | div_ovf;
    special_result_c = '0;
    if (div_by_zero) begin
      special_result_c = md_is_rem(op) ? src_a : '1;
    end else if (div_ovf) begin
      special_result_c = md_is_rem(op) ? '0 : INT_MIN;
    end
  end

  logic [XLEN:0]    rem_sh;
  logic             rem_ge;
  logic [XLEN-1:0]  rem_new;
  logic [ACC_W-1:0] acc_nxt;
  logic [ACC_W-1:0] prod;
  logic [XLEN-1:0]  quot, rem;

  // One iteration; the 33-bit compare keeps the shifted-out remainder MSB
  always_comb begin
    rem_sh  = {acc_q[ACC_W-1:XLEN], mcand_q[XLEN-1]};
    rem_ge  = rem_sh >= {1'b0, mplier_q};
    rem_new = rem_ge ? XLEN'(rem_sh - {1'b0, mplier_q}) : rem_sh[XLEN-1:0];
    if (md_is_div(op_q)) begin
      acc_nxt = {rem_new, acc_q[XLEN-2:0], rem_ge};
    end else begin
      acc_nxt = mplier_q[0] ? acc_q + mcand_q : acc_q;
    end
  end

  // Sign fix-up and final select, taken from the post-step accumulator
  always_comb begin
    prod = neg_q ? -acc_nxt : acc_nxt;
    quot = neg_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    rem  = rem_neg_q ? -acc_nxt[ACC_W-1:XLEN] : acc_nxt[ACC_W-1:XLEN];
    case (op_q)
      MD_MUL:                       result_c = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result_c = prod[ACC_W-1:XLEN];
      MD_DIV, MD_DIVU:              result_c = quot;
      default:                      result_c = rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= MD_MUL;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
    end else if (load) begin
      op_q      <= op;
      acc_q     <= '0;
      mcand_q   <= {XLEN'(0), a_mag};
      mplier_q  <= b_mag;
      neg_q     <= a_neg ^ b_neg;
      rem_neg_q <= a_neg;
    end else if (step) begin
      acc_q    <= acc_nxt;
      mcand_q  <= mcand_q << 1;
      mplier_q <= md_is_div(op_q) ? mplier_q : (mplier_q >> 1);
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative M-extension multiply/divide sequencer. Accepts an op from the
// execute stage, stalls the front of the pipe while iterating, then presents
// a registered result with a one-cycle done strobe.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   e_valid, e_op              execute-stage M-op request and funct3
//   e_src_a, e_src_b           forwarded rs1 / rs2 operands
//   e_flush                    execute-stage flush (aborts an op in flight)
//   md_stall                   combinational freeze of fetch/decode/execute
//   md_done                    one-cycle strobe, md_result valid
//   md_result                  registered result
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int unsigned MD_ITERS = MD_ITERS_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            e_valid,
  input  md_op_t          e_op,
  input  logic [XLEN-1:0] e_src_a,
  input  logic [XLEN-1:0] e_src_b,
  input  logic            e_flush,
  output logic            md_stall,
  output logic            md_done,
  output logic [XLEN-1:0] md_result
);

  localparam int unsigned CNT_W = (MD_ITERS > 1) ? $clog2(MD_ITERS) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MD_ITERS - 1);

  localparam logic [1:0] S_IDLE = 2'(MD_IDLE);
  localparam logic [1:0] S_BUSY = 2'(MD_BUSY);
  localparam logic [1:0] S_DONE = 2'(MD_DONE);

  logic [1:0]       state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             done_nxt;
  logic [XLEN-1:0]  result_nxt;
  logic             accept, step;
  logic             special_c;
  logic [XLEN-1:0]  special_result_c, result_c;

  muldiv_datapath u_datapath (
    .clk              (clk),
    .reset            (reset),
    .load             (accept),
    .step             (step),
    .op               (e_op),
    .src_a            (e_src_a),
    .src_b            (e_src_b),
    .special_c        (special_c),
    .special_result_c (special_result_c),
    .result_c         (result_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      md_done   <= 1'b0;
      md_result <= '0;
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      md_done   <= done_nxt;
      md_result <= result_nxt;
    end
  end

  // Next state, stall, and result capture on entry to DONE
  always_comb begin
    state_nxt  = state_q;
    cnt_nxt    = cnt_q;
    done_nxt   = 1'b0;
    result_nxt = md_result;
    accept     = 1'b0;
    step       = 1'b0;
    md_stall   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (e_valid && !e_flush) begin
          accept   = 1'b1;
          md_stall = 1'b1;
          cnt_nxt  = '0;
          if (special_c) begin
            state_nxt  = S_DONE;
            done_nxt   = 1'b1;
            result_nxt = special_result_c;
          end else begin
            state_nxt = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        md_stall = 1'b1;
        if (e_flush) begin
          state_nxt = S_IDLE;
        end else begin
          step    = 1'b1;
          cnt_nxt = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) begin
            state_nxt  = S_DONE;
            done_nxt   = 1'b1;
            result_nxt = result_c;
            cnt_nxt    = '0;
          end
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
